// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST sequencer.
package mbist_pkg;

  localparam int unsigned NUM_ELEMS = 6;
  localparam int unsigned ELEM_W    = 3;

  localparam logic B0 = 1'b0;
  localparam logic B1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CMP,
    ST_DONE
  } state_e;

  typedef logic [ELEM_W-1:0] elem_idx_t;

  // Backgrounds are one bit here and replicated across the word by the user.
  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic has_write;
    logic exp_bg;
    logic wr_bg;
  } elem_cfg_t;

  localparam elem_idx_t LAST_ELEM = ELEM_W'(NUM_ELEMS - 1);

  localparam elem_cfg_t [NUM_ELEMS-1:0] ELEM_TBL = '{
    0: '{dir_down: 1'b0, has_read: 1'b0, has_write: 1'b1, exp_bg: B0, wr_bg: B0},
    1: '{dir_down: 1'b0, has_read: 1'b1, has_write: 1'b1, exp_bg: B0, wr_bg: B1},
    2: '{dir_down: 1'b0, has_read: 1'b1, has_write: 1'b1, exp_bg: B1, wr_bg: B0},
    3: '{dir_down: 1'b1, has_read: 1'b1, has_write: 1'b1, exp_bg: B0, wr_bg: B1},
    4: '{dir_down: 1'b1, has_read: 1'b1, has_write: 1'b1, exp_bg: B1, wr_bg: B0},
    5: '{dir_down: 1'b0, has_read: 1'b1, has_write: 1'b0, exp_bg: B0, wr_bg: B0}
  };

endpackage

// File: rtl/mbisr_fault_log.sv
// Fault log for row repair: CAM-style match on logged addresses, in-order
// insert of new faulty addresses, and overflow once all spare rows are used.
module mbisr_fault_log
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned MAX_FAULTS = 2,
  localparam int unsigned CNT_W     = $clog2(MAX_FAULTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         valid,
  input  logic [ADDR_W-1:0]            addr,
  output logic                         hit,
  output logic [CNT_W-1:0]             cnt,
  output logic [MAX_FAULTS*ADDR_W-1:0] addrs,
  output logic                         overflow
);

  logic [MAX_FAULTS*ADDR_W-1:0] addrs_q, addrs_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;

  // Only populated entries take part in the match.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_FAULTS; i++) begin
      if ((CNT_W'(i) < cnt_q) && (addrs_q[i*ADDR_W +: ADDR_W] == addr)) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    addrs_d = addrs_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      addrs_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (valid && !hit) begin
      if (cnt_q < CNT_W'(MAX_FAULTS)) begin
        for (int unsigned i = 0; i < MAX_FAULTS; i++) begin
          if (CNT_W'(i) == cnt_q) begin
            addrs_d[i*ADDR_W +: ADDR_W] = addr;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrs_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      addrs_q <= addrs_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt      = cnt_q;
  assign addrs    = addrs_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/march_cminus_sequencer.sv
// March C- BIST sequencer: walks the six march elements over the SRAM,
// compares read data and feeds failing addresses to the repair fault log.
module march_cminus_sequencer
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_FAULTS = 2,
  localparam int unsigned CNT_W     = $clog2(MAX_FAULTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic                         any_err,
  output logic [CNT_W-1:0]             fault_cnt,
  output logic [MAX_FAULTS*ADDR_W-1:0] fault_addr
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e            state_q, state_d;
  elem_idx_t         elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  elem_idx_t         elem_inc;
  logic [ADDR_W-1:0] addr_step;
  logic [ADDR_W-1:0] first_addr_inc;
  logic              last_addr;
  logic              mismatch;
  logic              log_clear;
  logic              log_valid;
  logic              log_hit;

  assign elem_inc       = elem_q + ELEM_W'(1);
  assign last_addr      = ELEM_TBL[elem_q].dir_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
  assign addr_step      = ELEM_TBL[elem_q].dir_down ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
  assign first_addr_inc = ELEM_TBL[elem_inc].dir_down ? ADDR_LAST : '0;

  // Read data arrives in CMP, one cycle after the RD that requested it.
  assign mismatch  = (state_q == ST_CMP) && ELEM_TBL[elem_q].has_read &&
                     (mem_rdata != {DATA_W{ELEM_TBL[elem_q].exp_bg}});
  assign log_valid = mismatch && !log_hit;

  // Next state and next values of the registered SRAM/status outputs.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    log_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WR;
          elem_d    = '0;
          addr_d    = '0;
          we_d      = 1'b1;
          wdata_d   = {DATA_W{B0}};
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          log_clear = 1'b1;
        end
      end
      ST_WR: begin
        if (last_addr) begin
          state_d = ST_RD;
          elem_d  = elem_inc;
          addr_d  = first_addr_inc;
          re_d    = 1'b1;
        end else begin
          addr_d  = addr_step;
          we_d    = 1'b1;
          wdata_d = {DATA_W{ELEM_TBL[elem_q].wr_bg}};
        end
      end
      ST_RD: begin
        state_d = ST_CMP;
        we_d    = ELEM_TBL[elem_q].has_write;
        if (ELEM_TBL[elem_q].has_write) begin
          wdata_d = {DATA_W{ELEM_TBL[elem_q].wr_bg}};
        end
      end
      ST_CMP: begin
        if (mismatch) begin
          err_d = 1'b1;
        end
        if (last_addr && (elem_q == LAST_ELEM)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (last_addr) begin
          state_d = ST_RD;
          elem_d  = elem_inc;
          addr_d  = first_addr_inc;
          re_d    = 1'b1;
        end else begin
          state_d = ST_RD;
          addr_d  = addr_step;
          re_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  mbisr_fault_log #(
    .ADDR_W     (ADDR_W),
    .MAX_FAULTS (MAX_FAULTS)
  ) u_fault_log (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (log_clear),
    .valid    (log_valid),
    .addr     (addr_q),
    .hit      (log_hit),
    .cnt      (fault_cnt),
    .addrs    (fault_addr),
    .overflow (fail)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign any_err   = err_q;

endmodule

// File: tb/tb_march_cminus_sequencer.sv
// Bench for the March C- sequencer: SRAM model with stuck-at faults, an
// algorithm-level expected port trace and an expected fault-log result.
module tb_march_cminus_sequencer;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned MAX_FAULTS = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int          N          = 16;
  localparam int          RUN_CYCLES = 11 * N;
  localparam int          CYC_LIMIT  = 400;

  typedef struct packed {
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         start;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_we;
  logic                         mem_re;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         busy;
  logic                         done;
  logic                         fail;
  logic                         any_err;
  logic [CNT_W-1:0]             fault_cnt;
  logic [MAX_FAULTS*ADDR_W-1:0] fault_addr;

  // March C- as listed: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
  logic [5:0] e_down  = 6'b011000;
  logic [5:0] e_hasw  = 6'b011111;
  logic [5:0] e_expbg = 6'b010100;
  logic [5:0] e_wrbg  = 6'b001010;

  int  vectors     = 0;
  int  miscompares = 0;
  int  busy_cycles = 0;
  int  we_cnt      = 0;
  int  re_cnt      = 0;
  bit  track       = 1'b0;
  op_t exp_q[$];

  logic [DATA_W-1:0] sram [N];
  logic [DATA_W-1:0] sa0  [N];
  logic [DATA_W-1:0] sa1  [N];

  always #5 clk = ~clk;

  march_cminus_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_FAULTS (MAX_FAULTS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .any_err    (any_err),
    .fault_cnt  (fault_cnt),
    .fault_addr (fault_addr)
  );

  // SRAM with per-address stuck-at masks and one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= (mem_wdata | sa1[mem_addr]) & ~sa0[mem_addr];
    if (mem_re) mem_rdata <= (sram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_clean();
    for (int a = 0; a < N; a++) begin
      sa0[a] = '0;
      sa1[a] = '0;
    end
  endtask

  // Expected SRAM port activity, one entry per busy cycle.
  task automatic build_plan();
    int a;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back('{1'b1, 1'b0, ADDR_W'(k), DATA_W'(0)});
    for (int e = 1; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = e_down[e] ? (N - 1 - k) : k;
        exp_q.push_back('{1'b0, 1'b1, ADDR_W'(a), DATA_W'(0)});
        exp_q.push_back('{e_hasw[e], 1'b0, ADDR_W'(a),
                          e_hasw[e] ? {DATA_W{e_wrbg[e]}} : DATA_W'(0)});
      end
    end
  endtask

  // Runs the march on a private copy of the faulty memory to get the expected log.
  task automatic predict(output logic [CNT_W-1:0] p_cnt,
                         output logic [MAX_FAULTS*ADDR_W-1:0] p_addrs,
                         output logic p_fail, output logic p_err);
    logic [DATA_W-1:0] m [N];
    int                log_q[$];
    int                a;
    bit                found;
    p_fail = 1'b0;
    p_err  = 1'b0;
    for (int k = 0; k < N; k++) m[k] = (DATA_W'(0) | sa1[k]) & ~sa0[k];
    for (int e = 1; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = e_down[e] ? (N - 1 - k) : k;
        if (m[a] != {DATA_W{e_expbg[e]}}) begin
          p_err = 1'b1;
          found = 1'b0;
          foreach (log_q[j]) if (log_q[j] == a) found = 1'b1;
          if (!found) begin
            if (log_q.size() < MAX_FAULTS) log_q.push_back(a);
            else p_fail = 1'b1;
          end
        end
        if (e_hasw[e]) m[a] = ({DATA_W{e_wrbg[e]}} | sa1[a]) & ~sa0[a];
      end
    end
    p_cnt   = CNT_W'(log_q.size());
    p_addrs = '0;
    foreach (log_q[j]) p_addrs[j*ADDR_W +: ADDR_W] = ADDR_W'(log_q[j]);
  endtask

  // Per-cycle compare of the SRAM port against the expected trace.
  always @(negedge clk) begin
    if (track && busy) begin
      busy_cycles++;
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_busy_cycle", 64'(busy_cycles), 64'(RUN_CYCLES));
      end else begin
        op_t e;
        e = exp_q.pop_front();
        check("sram_port", 64'({done, mem_we, mem_re, mem_addr, mem_we ? mem_wdata : DATA_W'(0)}),
              64'({1'b0, e}));
      end
    end
  end

  task automatic run(input string tag, input int glitch_at, input int reset_at);
    int                           cyc;
    logic [CNT_W-1:0]             p_cnt;
    logic [MAX_FAULTS*ADDR_W-1:0] p_addrs;
    logic                         p_fail;
    logic                         p_err;
    build_plan();
    predict(p_cnt, p_addrs, p_fail, p_err);
    busy_cycles = 0;
    we_cnt      = 0;
    re_cnt      = 0;
    track       = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    cyc   = 1;
    while (busy && cyc < CYC_LIMIT) begin
      @(posedge clk);
      #2;
      cyc++;
      if (cyc == glitch_at) start = 1'b1;
      if (cyc == glitch_at + 1) start = 1'b0;
      if (cyc == reset_at) begin
        check({tag, "_we_before_reset"}, 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check({tag, "_async_reset"}, 64'({busy, done, fail, any_err, mem_we, mem_re,
              fault_cnt, fault_addr, mem_addr, mem_wdata}), 64'd0);
        track = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_idle_after_reset"}, 64'({busy, done, mem_we, mem_re}), 64'd0);
        return;
      end
    end
    if (cyc >= CYC_LIMIT) check({tag, "_timeout"}, 64'(cyc), 64'(RUN_CYCLES + 1));
    @(negedge clk);
    #1;
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(RUN_CYCLES));
    check({tag, "_trace_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_done"}, 64'({busy, done}), 64'(2'b01));
    check({tag, "_result"}, 64'({any_err, fail, fault_cnt, fault_addr}),
          64'({p_err, p_fail, p_cnt, p_addrs}));
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_held"}, 64'({done, busy, mem_we, mem_re, any_err, fail, fault_cnt, fault_addr}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, p_err, p_fail, p_cnt, p_addrs}));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_clean();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, fail, any_err, mem_we, mem_re,
          fault_cnt, fault_addr, mem_addr, mem_wdata}), 64'd0);
    rst_n = 1'b1;

    run("clean", 0, 0);
    check("clean_we_count", 64'(we_cnt), 64'd80);
    check("clean_re_count", 64'(re_cnt), 64'd80);
    check("clean_result", 64'({any_err, fail, fault_cnt}), 64'd0);

    set_clean();
    sa0[5] = 8'h08;
    run("sa0_a5", 0, 0);
    check("sa0_a5_log", 64'({any_err, fail, fault_cnt, fault_addr[3:0]}),
          64'({1'b1, 1'b0, 2'd1, 4'd5}));

    set_clean();
    sa0[2] = 8'h01;
    sa0[9] = 8'h01;
    run("sa0_a2_a9", 0, 0);
    check("sa0_a2_a9_log", 64'({any_err, fail, fault_cnt, fault_addr}),
          64'({1'b1, 1'b0, 2'd2, 8'h92}));

    set_clean();
    sa1[1] = 8'h01;
    sa1[4] = 8'h01;
    sa1[7] = 8'h01;
    run("sa1_overflow", 0, 0);
    check("sa1_overflow_log", 64'({done, any_err, fail, fault_cnt, fault_addr}),
          64'({1'b1, 1'b1, 1'b1, 2'd2, 8'h41}));

    set_clean();
    run("restart_glitch", 40, 0);
    check("restart_cleared", 64'({any_err, fail, fault_cnt, fault_addr}), 64'd0);

    run("mid_reset", 0, 60);
    run("after_reset", 0, 0);
    check("after_reset_we_count", 64'(we_cnt), 64'd80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/march_cminus_sequencer.md
Name: march_cminus_sequencer

Overview:
- Sequences a March C- test over the on-chip SRAM and logs failing addresses for row repair.
- Sits between the top-level start/done/fail pins and the SRAM port.
- Drives address, data and enables on the SRAM, compares the read data, and captures up to MAX_FAULTS distinct faulty addresses.
- The repair mux downstream consumes those addresses.

Parameters:
- ADDR_W, 4, SRAM address width; depth N = 2**ADDR_W.
- DATA_W, 8, SRAM word width.
- MAX_FAULTS, 2, number of spare-row entries in the fault log.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled start request; acted on only in IDLE or DONE
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_we  out  1  SRAM write enable
- mem_re  out  1  SRAM read enable; mem_rdata is valid the cycle after
- mem_rdata  in  DATA_W  SRAM read data
- busy  out  1  test in progress
- done  out  1  test complete; held until next start or reset
- fail  out  1  unrepairable: more than MAX_FAULTS distinct faulty addresses
- any_err  out  1  at least one mismatch seen this run
- fault_cnt  out  $clog2(MAX_FAULTS+1)  number of logged addresses
- fault_addr  out  MAX_FAULTS*ADDR_W  logged addresses; entry i is at bits [i*ADDR_W +: ADDR_W]

Behaviour:
- Reset (asynchronous, takes effect mid-run too): all outputs 0; state IDLE; fault log cleared.
- States: IDLE, WR, RD, CMP, DONE.
- March elements, in order, with background B0 = all-0 and B1 = all-1:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- Up sweeps run address 0 to N-1; down sweeps run N-1 to 0. The element index and address counter advance at the last cycle of each address.
- IDLE/DONE + start=1 at an edge: clear log, any_err and fail; done=0; busy=1; enter E0 WR at address 0.
- WR (E0 only): mem_we=1, mem_wdata=B0; one cycle per address.
- RD: mem_re=1 at the current address.
- CMP: compare mem_rdata against the expected background.
  - Elements E1–E4: mem_we=1 in this same cycle, writing the opposite background to the same address.
  - E5: no write.
- Cycle count per element: E0 N cycles; E1–E5 2N cycles each. busy is high for exactly 11*N cycles (176 at default).
- The last CMP of E5 goes to DONE: busy=0 and done=1, both registered on the same edge.
- mem_we and mem_re are never both 1. mem_addr holds its value in IDLE/DONE; enables are 0 there.
- start while busy is ignored.
- On mismatch in CMP:
  - any_err is set.
  - If the address is already logged, there is no change.
  - Otherwise, if fault_cnt < MAX_FAULTS, the address goes into entry fault_cnt and fault_cnt increments.
  - Otherwise fail is set (sticky for the run) and the log is unchanged.
- The match check and the insert happen in one cycle. A back-to-back mismatch at the next address sees the updated log.
- Results (fail, any_err, fault_cnt, fault_addr) are stable from the DONE edge until the next start.

Decomposition:
- Package mbist_pkg holds:
  - state enum
  - element encoding (direction, has_read, has_write, expected background, write background) as a constant table indexed by element
  - B0/B1 constants
  - NUM_ELEMS = 6
- Sub-module mbisr_fault_log holds the CAM-style match, the insert, fault_cnt and overflow→fail.
  - Inputs: clear, valid, addr.
  - Outputs: hit, cnt, addrs, overflow.
  - The sequencer instantiates it once.

Test Plan:
- Fault-free SRAM model (1-cycle read latency), start pulse for 1 cycle → busy high exactly 176 cycles; done=1, fail=0, any_err=0, fault_cnt=0. Check that mem_we fires 80 times and mem_re 80 times.
- Bit 3 stuck-at-0 at address 5 → mismatches only in E2, E4 (read-1 elements), logged once; done=1, any_err=1, fault_cnt=1, fault_addr[3:0]=5, fail=0.
- Stuck-at-0 at addresses 2 and 9 → fault_cnt=2, entry0=2, entry1=9 (E2 ascending order), fail=0.
- Stuck-at-1 at addresses 1, 4, 7 → first mismatch in E1; fault_cnt=2, entries 1 and 4, fail=1, done=1.
- start re-asserted at cycle 40 of a run → ignored, still 176 cycles total. Second run started from DONE with a fault-free model → log cleared, any_err=0.
- rst_n low for 2 cycles at cycle 60 → outputs 0 asynchronously, mem_we=0 immediately. New start completes normally in 176 cycles.
